// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, widths, FSM encoding and the ID/EX bundle.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;
    typedef enum logic [1:0] {WD_NONE, WD_RD, WD_RT} wdest_sel_t;
    typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_LUI, IMM_JUMP} imm_mode_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wdest;
        logic [DATA_W-1:0] imm;
        ctrl_t             ctrl;
    } idex_t;

    function automatic logic [DATA_W-1:0] extend_imm(imm_mode_t mode, logic [25:0] field);
        case (mode)
            IMM_ZERO: extend_imm = {16'b0, field[15:0]};
            IMM_LUI:  extend_imm = {field[15:0], 16'b0};
            IMM_JUMP: extend_imm = {6'b0, field};
            default:  extend_imm = {{16{field[15]}}, field[15:0]};
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: destination select, immediate mode, control bits, illegal flag.
module decode_ctrl
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output wdest_sel_t wdest_sel,
    output imm_mode_t  imm_mode,
    output ctrl_t      ctrl,
    output logic       uses_rt,
    output logic       illegal
);

    always_comb begin
        wdest_sel = WD_NONE;
        imm_mode  = IMM_SIGN;
        ctrl      = '0;
        uses_rt   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin wdest_sel = WD_RD; uses_rt = 1'b1; end
            OP_ADDI:  wdest_sel = WD_RT;
            OP_ANDI:  begin wdest_sel = WD_RT; imm_mode = IMM_ZERO; end
            OP_ORI:   begin wdest_sel = WD_RT; imm_mode = IMM_ZERO; end
            OP_LUI:   begin wdest_sel = WD_RT; imm_mode = IMM_LUI; end
            OP_LW:    begin wdest_sel = WD_RT; ctrl.mem_read = 1'b1; end
            OP_SW:    begin ctrl.mem_write = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin ctrl.branch = 1'b1; uses_rt = 1'b1; end
            OP_BNE:   begin ctrl.branch = 1'b1; uses_rt = 1'b1; end
            OP_J:     begin ctrl.jump = 1'b1; imm_mode = IMM_JUMP; end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes into the ID/EX register (1-cycle latency), aligns bank read data,
// bypasses same-cycle writeback, stalls fetch for one bubble on load-use.
module instruction_decode
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_instr,
    output logic              if_stall,
    input  logic              flush,
    output logic [REG_AW-1:0] addra,
    output logic [REG_AW-1:0] addrb,
    input  logic [DATA_W-1:0] dataa,
    input  logic [DATA_W-1:0] datab,
    input  logic              wb_enc,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rt,
    output logic [REG_AW-1:0] id_wdest,
    output logic [DATA_W-1:0] id_imm,
    output logic [DATA_W-1:0] id_rs_val,
    output logic [DATA_W-1:0] id_rt_val,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_reg_write,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_illegal
);

    state_t            state_q;
    idex_t             idex_q, idex_d;
    logic              illegal_q;
    logic              byp_a_q, byp_b_q;
    logic [DATA_W-1:0] wbd_q;

    wdest_sel_t wdest_sel;
    imm_mode_t  imm_mode;
    ctrl_t      dec_ctrl;
    logic       uses_rt, dec_illegal, hazard;

    assign addra = if_instr[25:21];
    assign addrb = if_instr[20:16];

    decode_ctrl u_decode_ctrl (
        .opcode    (if_instr[31:26]),
        .wdest_sel (wdest_sel),
        .imm_mode  (imm_mode),
        .ctrl      (dec_ctrl),
        .uses_rt   (uses_rt),
        .illegal   (dec_illegal)
    );

    always_comb begin
        idex_d        = '0;
        idex_d.valid  = 1'b1;
        idex_d.pc     = if_pc;
        idex_d.opcode = if_instr[31:26];
        idex_d.funct  = (if_instr[31:26] == OP_RTYPE) ? if_instr[5:0] : 6'b0;
        idex_d.rs     = if_instr[25:21];
        idex_d.rt     = if_instr[20:16];
        idex_d.imm    = extend_imm(imm_mode, if_instr[25:0]);
        idex_d.ctrl   = dec_ctrl;
        case (wdest_sel)
            WD_RD:   idex_d.wdest = if_instr[15:11];
            WD_RT:   idex_d.wdest = if_instr[20:16];
            default: idex_d.wdest = '0;
        endcase
    end

    // Load-use: the load in ID/EX has not produced data yet when the consumer would read.
    assign hazard = idex_q.valid && idex_q.ctrl.mem_read && (idex_q.wdest != '0) && if_valid &&
                    ((addra == idex_q.wdest) || (uses_rt && addrb == idex_q.wdest));

    assign if_stall = !reset && !flush && (state_q == ST_RUN) && hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            idex_q    <= '0;
            illegal_q <= 1'b0;
            byp_a_q   <= 1'b0;
            byp_b_q   <= 1'b0;
            wbd_q     <= '0;
        end else begin
            byp_a_q   <= wb_enc && (wb_addr == addra) && (wb_addr != '0);
            byp_b_q   <= wb_enc && (wb_addr == addrb) && (wb_addr != '0);
            wbd_q     <= wb_data;
            illegal_q <= 1'b0;
            if (flush) begin
                state_q <= ST_RUN;
                idex_q  <= '0;
            end else if (state_q == ST_RUN && hazard) begin
                state_q <= ST_BUBBLE;
                idex_q  <= '0;
            end else begin
                state_q <= ST_RUN;
                if (if_valid && !dec_illegal) begin
                    idex_q <= idex_d;
                end else begin
                    idex_q    <= '0;
                    illegal_q <= if_valid && dec_illegal;
                end
            end
        end
    end

    assign id_valid     = idex_q.valid;
    assign id_pc        = idex_q.pc;
    assign id_opcode    = idex_q.opcode;
    assign id_funct     = idex_q.funct;
    assign id_rs        = idex_q.rs;
    assign id_rt        = idex_q.rt;
    assign id_wdest     = idex_q.wdest;
    assign id_imm       = idex_q.imm;
    assign id_mem_read  = idex_q.ctrl.mem_read;
    assign id_mem_write = idex_q.ctrl.mem_write;
    assign id_branch    = idex_q.ctrl.branch;
    assign id_jump      = idex_q.ctrl.jump;
    assign id_reg_write = (idex_q.wdest != '0);
    assign id_illegal   = illegal_q;

    assign id_rs_val = (idex_q.rs == '0) ? '0 : (byp_a_q ? wbd_q : dataa);
    assign id_rt_val = (idex_q.rt == '0) ? '0 : (byp_b_q ? wbd_q : datab);

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with a synchronous-read register bank model.
module tb_instruction_decode;

    logic        clock = 1'b0;
    logic        reset, if_valid, flush, wb_enc;
    logic [31:0] if_pc, if_instr, wb_data;
    logic [4:0]  wb_addr, addra, addrb;
    logic [31:0] dataa, datab;
    logic        if_stall, id_valid, id_mem_read, id_mem_write, id_reg_write;
    logic        id_branch, id_jump, id_illegal;
    logic [31:0] id_pc, id_imm, id_rs_val, id_rt_val;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_wdest;

    logic [31:0] mem [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    instruction_decode dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_stall(if_stall), .flush(flush), .addra(addra), .addrb(addrb), .dataa(dataa),
        .datab(datab), .wb_enc(wb_enc), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_wdest(id_wdest), .id_imm(id_imm),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_branch(id_branch),
        .id_jump(id_jump), .id_illegal(id_illegal)
    );

    // Bank: 1-cycle synchronous read, old data on read/write collision.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
            mem[0] <= 32'hFFFF_FFFF;
            mem[1] <= 32'd10;
        end else if (wb_enc) begin
            mem[wb_addr] <= wb_data;
        end
        dataa <= mem[addra];
        datab <= mem[addrb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; flush = 1'b0; wb_enc = 1'b0;
        if_pc = '0; if_instr = '0; wb_addr = '0; wb_data = '0;
        tick();
        #1 check("rst_stall", {31'b0, if_stall}, 32'd0);
        tick();
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_imm", id_imm, 32'd0);
        reset = 1'b0;

        // addi r2,r1,-4
        drive(32'h100, 32'h2022FFFC);
        #1 check("addra", {27'b0, addra}, 32'd1);
        tick();
        check("addi_valid", {31'b0, id_valid}, 32'd1);
        check("addi_rs", {27'b0, id_rs}, 32'd1);
        check("addi_wdest", {27'b0, id_wdest}, 32'd2);
        check("addi_imm", id_imm, 32'hFFFF_FFFC);
        check("addi_rsval", id_rs_val, 32'd10);
        check("addi_pc", id_pc, 32'h100);
        check("addi_regw", {31'b0, id_reg_write}, 32'd1);

        // add r3,r1,r1 with concurrent writeback of r1
        drive(32'h104, 32'h00211820);
        wb_enc = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        tick();
        wb_enc = 1'b0;
        check("byp_rsval", id_rs_val, 32'h55);
        check("byp_rtval", id_rt_val, 32'h55);
        check("add_wdest", {27'b0, id_wdest}, 32'd3);
        check("add_funct", {26'b0, id_funct}, 32'h20);

        // lw r4,0(r1) then add r5,r4,r4: one bubble
        drive(32'h108, 32'h8C240000);
        tick();
        check("lw_memrd", {31'b0, id_mem_read}, 32'd1);
        check("lw_rsval", id_rs_val, 32'h55);
        drive(32'h10C, 32'h00842820);
        #1 check("lu_stall", {31'b0, if_stall}, 32'd1);
        tick();
        check("lu_bubble", {31'b0, id_valid}, 32'd0);
        #1 check("lu_stall2", {31'b0, if_stall}, 32'd0);
        tick();
        check("lu_valid", {31'b0, id_valid}, 32'd1);
        check("lu_wdest", {27'b0, id_wdest}, 32'd5);
        check("lu_rsval", id_rs_val, 32'd4);

        // lw r4 then sub r5,r6,r7: independent, no stall
        drive(32'h110, 32'h8C240000);
        tick();
        drive(32'h114, 32'h00C72822);
        #1 check("ind_stall", {31'b0, if_stall}, 32'd0);
        tick();
        check("ind_valid", {31'b0, id_valid}, 32'd1);
        check("ind_rsval", id_rs_val, 32'd6);
        check("ind_rtval", id_rt_val, 32'd7);

        // lw r4 then ori r4,r2,1: rt matches but is not a source
        drive(32'h118, 32'h8C240000);
        tick();
        drive(32'h11C, 32'h34440001);
        #1 check("ori_stall", {31'b0, if_stall}, 32'd0);
        tick();
        check("ori_valid", {31'b0, id_valid}, 32'd1);

        // flush while a load-use hazard is pending
        drive(32'h120, 32'h8C240000);
        tick();
        drive(32'h124, 32'h00842820);
        flush = 1'b1;
        #1 check("fl_stall", {31'b0, if_stall}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_bubble", {31'b0, id_valid}, 32'd0);
        drive(32'h200, 32'h00C72822);
        #1 check("fl_run_stall", {31'b0, if_stall}, 32'd0);
        tick();
        check("fl_run_valid", {31'b0, id_valid}, 32'd1);
        check("fl_run_pc", id_pc, 32'h200);

        // illegal opcode 0x3F
        drive(32'h204, 32'hFC000000);
        #1 check("ill_stall", {31'b0, if_stall}, 32'd0);
        tick();
        check("ill_valid", {31'b0, id_valid}, 32'd0);
        check("ill_flag", {31'b0, id_illegal}, 32'd1);

        // andi r2,r1,0x8000
        drive(32'h208, 32'h30228000);
        tick();
        check("ill_pulse", {31'b0, id_illegal}, 32'd0);
        check("andi_imm", id_imm, 32'h0000_8000);
        check("andi_wdest", {27'b0, id_wdest}, 32'd2);

        // lui r3,0x1234
        drive(32'h20C, 32'h3C031234);
        tick();
        check("lui_imm", id_imm, 32'h1234_0000);

        // addi r5,r0,7 with bank r0 reading all ones
        drive(32'h210, 32'h20050007);
        tick();
        check("r0_rsval", id_rs_val, 32'd0);
        check("r0_imm", id_imm, 32'd7);

        // sw r2,4(r1)
        drive(32'h214, 32'hAC220004);
        tick();
        check("sw_wdest", {27'b0, id_wdest}, 32'd0);
        check("sw_memwr", {31'b0, id_mem_write}, 32'd1);
        check("sw_regw", {31'b0, id_reg_write}, 32'd0);

        // beq r1,r2,-1
        drive(32'h218, 32'h1022FFFF);
        tick();
        check("beq_branch", {31'b0, id_branch}, 32'd1);
        check("beq_imm", id_imm, 32'hFFFF_FFFF);

        // j 0x10
        drive(32'h21C, 32'h08000010);
        tick();
        check("j_jump", {31'b0, id_jump}, 32'd1);
        check("j_imm", id_imm, 32'h10);
        check("j_wdest", {27'b0, id_wdest}, 32'd0);

        if_valid = 1'b0;
        tick();
        check("idle_valid", {31'b0, id_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
